mb32_cell_ctrl: RTL and testbench



---
 rtl/mb32_cell_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mb32_cell_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mb32_cell_ctrl.sv
// Byte-addressed cell access controller for the eForth load/store unit.
// Splits word-crossing accesses into two aligned SPRAM word accesses with lane masks.
module mb32_cell_ctrl #(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-3:0] m_ai,
  output logic [DW-1:0] m_vi,
  output logic          m_we,
  output logic [3:0]    m_bmsk,
  input  logic [DW-1:0] m_vo
);

  typedef enum logic [1:0] {IDLE, A0, A1, RL} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    sz_q, sz_d;
  logic [1:0]    off_q, off_d;
  logic [AW-3:0] w1_q, w1_d;
  logic          split_q, split_d;
  logic [3:0]    mhi_q, mhi_d;
  logic [DW-1:0] dhi_q, dhi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] m_vi_q, m_vi_d;
  logic [AW-3:0] m_ai_q, m_ai_d;
  logic          m_we_q, m_we_d;
  logic [3:0]    m_bmsk_q, m_bmsk_d;
  logic          done_q, done_d;

  // Request decode, only meaningful in the accept cycle
  logic [1:0]  req_sz;
  logic [2:0]  n_bytes;
  logic [3:0]  span;
  logic [7:0]  lmask;
  logic [7:0]  mask8;
  logic [63:0] data64;

  assign req_sz  = (size == 2'd3) ? 2'd2 : size;
  assign n_bytes = 3'd1 << req_sz;
  assign span    = {2'b00, addr[1:0]} + {1'b0, n_bytes};
  assign mask8   = lmask << addr[1:0];
  assign data64  = {32'b0, wdata} << {addr[1:0], 3'b000};

  always_comb begin
    lmask = 8'h0F;
    case (req_sz)
      2'd0:    lmask = 8'h01;
      2'd1:    lmask = 8'h03;
      default: lmask = 8'h0F;
    endcase
  end

  // Read reassembly: hi is only meaningful when the access was split
  logic [63:0]   rd_cat;
  logic [63:0]   rd_shift;
  logic [DW-1:0] rd_keep;

  assign rd_cat   = split_q ? {m_vo, lo_q} : {32'b0, m_vo};
  assign rd_shift = rd_cat >> {off_q, 3'b000};

  always_comb begin
    rd_keep = '1;
    case (sz_q)
      2'd0:    rd_keep = 32'h0000_00FF;
      2'd1:    rd_keep = 32'h0000_FFFF;
      default: rd_keep = '1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sz_d     = sz_q;
    off_d    = off_q;
    w1_d     = w1_q;
    split_d  = split_q;
    mhi_d    = mhi_q;
    dhi_d    = dhi_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    m_vi_d   = m_vi_q;
    m_ai_d   = m_ai_q;
    m_we_d   = 1'b0;
    m_bmsk_d = '0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = A0;
          we_d     = we;
          sz_d     = req_sz;
          off_d    = addr[1:0];
          w1_d     = addr[AW-1:2] + (AW-2)'(1);
          split_d  = (span > 4'd4);
          mhi_d    = mask8[7:4];
          dhi_d    = data64[63:32];
          m_ai_d   = addr[AW-1:2];
          m_bmsk_d = mask8[3:0];
          m_we_d   = we;
          if (we) m_vi_d = data64[31:0];
        end
      end
      A0: begin
        if (split_q) begin
          state_d  = A1;
          m_ai_d   = w1_q;
          m_bmsk_d = mhi_q;
          m_we_d   = we_q;
          if (we_q) m_vi_d = dhi_q;
        end else if (we_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RL;
        end
      end
      A1: begin
        if (we_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lo_d    = m_vo;
          state_d = RL;
        end
      end
      RL: begin
        rdata_d = rd_shift[31:0] & rd_keep;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      sz_q     <= '0;
      off_q    <= '0;
      w1_q     <= '0;
      split_q  <= 1'b0;
      mhi_q    <= '0;
      dhi_q    <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      m_vi_q   <= '0;
      m_ai_q   <= '0;
      m_we_q   <= 1'b0;
      m_bmsk_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sz_q     <= sz_d;
      off_q    <= off_d;
      w1_q     <= w1_d;
      split_q  <= split_d;
      mhi_q    <= mhi_d;
      dhi_q    <= dhi_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
      m_vi_q   <= m_vi_d;
      m_ai_q   <= m_ai_d;
      m_we_q   <= m_we_d;
      m_bmsk_q <= m_bmsk_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign m_ai   = m_ai_q;
  assign m_vi   = m_vi_q;
  assign m_we   = m_we_q;
  assign m_bmsk = m_bmsk_q;

endmodule

// File: tb/tb_mb32_cell_ctrl.sv
// Directed bench for mb32_cell_ctrl with a behavioural SPRAM (registered read, lane-masked write).
module tb_mb32_cell_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [16:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done;
  logic [31:0] rdata;
  logic [14:0] m_ai;
  logic [31:0] m_vi;
  logic        m_we;
  logic [3:0]  m_bmsk;
  logic [31:0] m_vo;

  int checks = 0;
  int failures = 0;

  mb32_cell_ctrl #(.AW(17), .DW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .m_ai(m_ai), .m_vi(m_vi), .m_we(m_we), .m_bmsk(m_bmsk), .m_vo(m_vo)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (m_we)
      for (int i = 0; i < 4; i++)
        if (m_bmsk[i]) mem[m_ai][8*i +: 8] <= m_vi[8*i +: 8];
    m_vo <= mem[m_ai];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in cycle T+1
  task automatic issue(input logic w, input logic [1:0] sz, input logic [16:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    step();
    req = 1'b0;
  endtask

  // Called in cycle T+1; cyc = k when done pulses in cycle T+k (20 means it never came)
  task automatic run_to_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; we = 1'b1; size = 2'd2; addr = 17'h00010; wdata = 32'h12345678;
    step(); step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (m_ai !== 15'h0) begin failures++; $display("FAIL rst_m_ai got=%h exp=0", m_ai); end
    checks++; if (m_vi !== 32'h0) begin failures++; $display("FAIL rst_m_vi got=%h exp=0", m_vi); end
    checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL rst_m_we got=%b exp=0", m_we); end
    checks++; if (m_bmsk !== 4'h0) begin failures++; $display("FAIL rst_m_bmsk got=%h exp=0", m_bmsk); end
    rst = 1'b0; req = 1'b0;
    step();
    checks++; if ({ready, m_we, m_bmsk} !== 6'b10_0000) begin failures++; $display("FAIL rst_req_ignored got=%b exp=100000", {ready, m_we, m_bmsk}); end
  endtask

  task automatic test_aligned();
    int cyc;
    issue(1'b1, 2'd2, 17'h00010, 32'hDEADBEEF);
    checks++; if (m_ai !== 15'h0004) begin failures++; $display("FAIL al_w_m_ai got=%h exp=0004", m_ai); end
    checks++; if (m_bmsk !== 4'hF) begin failures++; $display("FAIL al_w_bmsk got=%h exp=f", m_bmsk); end
    checks++; if (m_we !== 1'b1) begin failures++; $display("FAIL al_w_m_we got=%b exp=1", m_we); end
    checks++; if (m_vi !== 32'hDEADBEEF) begin failures++; $display("FAIL al_w_m_vi got=%h exp=deadbeef", m_vi); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL al_w_busy got=%b exp=0", ready); end
    step();
    checks++; if ({done, ready, m_we, m_bmsk} !== 7'b110_0000) begin failures++; $display("FAIL al_w_done got=%b exp=1100000", {done, ready, m_we, m_bmsk}); end
    step();
    issue(1'b0, 2'd2, 17'h00010, 32'h0);
    checks++; if ({m_we, m_bmsk, m_ai} !== {1'b0, 4'hF, 15'h0004}) begin failures++; $display("FAIL al_r_a0 got=%b/%h/%h exp=0/f/0004", m_we, m_bmsk, m_ai); end
    run_to_done(cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL al_r_lat got=%0d exp=3", cyc); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL al_r_data got=%h exp=deadbeef", rdata); end
    step();
    checks++; if ({done, rdata} !== {1'b0, 32'hDEADBEEF}) begin failures++; $display("FAIL al_r_hold got=%b/%h exp=0/deadbeef", done, rdata); end
  endtask

  task automatic test_byte();
    int cyc;
    issue(1'b1, 2'd2, 17'h00020, 32'h0C0B0A09); run_to_done(cyc); step();
    issue(1'b1, 2'd0, 17'h00022, 32'h000000A5);
    checks++; if ({m_ai, m_bmsk} !== {15'h0008, 4'h4}) begin failures++; $display("FAIL byte_a0 got=%h/%h exp=0008/4", m_ai, m_bmsk); end
    checks++; if (m_vi[23:16] !== 8'hA5) begin failures++; $display("FAIL byte_vi got=%h exp=a5", m_vi[23:16]); end
    run_to_done(cyc);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL byte_w_lat got=%0d exp=2", cyc); end
    step();
    issue(1'b0, 2'd2, 17'h00020, 32'h0); run_to_done(cyc);
    checks++; if (rdata !== 32'h0CA50A09) begin failures++; $display("FAIL byte_word_rd got=%h exp=0ca50a09", rdata); end
    step();
    issue(1'b0, 2'd0, 17'h00022, 32'h0); run_to_done(cyc);
    checks++; if (rdata !== 32'h000000A5) begin failures++; $display("FAIL byte_rd got=%h exp=000000a5", rdata); end
    step();
    issue(1'b0, 2'd1, 17'h00021, 32'h0); run_to_done(cyc);
    checks++; if (rdata !== 32'h0000A50A) begin failures++; $display("FAIL half_rd_off1 got=%h exp=0000a50a", rdata); end
    step();
    issue(1'b0, 2'd3, 17'h00020, 32'h0); run_to_done(cyc);
    checks++; if ({cyc[3:0], rdata} !== {4'd3, 32'h0CA50A09}) begin failures++; $display("FAIL size3_rd got=%0d/%h exp=3/0ca50a09", cyc, rdata); end
    step();
  endtask

  task automatic test_split();
    int cyc;
    issue(1'b1, 2'd2, 17'h00007, 32'h11223344);
    checks++; if ({m_ai, m_bmsk, m_we} !== {15'h0001, 4'h8, 1'b1}) begin failures++; $display("FAIL split_a0 got=%h/%h/%b exp=0001/8/1", m_ai, m_bmsk, m_we); end
    checks++; if (m_vi[31:24] !== 8'h44) begin failures++; $display("FAIL split_a0_vi got=%h exp=44", m_vi[31:24]); end
    step();
    checks++; if ({m_ai, m_bmsk, m_we, done} !== {15'h0002, 4'h7, 1'b1, 1'b0}) begin failures++; $display("FAIL split_a1 got=%h/%h/%b/%b exp=0002/7/1/0", m_ai, m_bmsk, m_we, done); end
    checks++; if (m_vi[23:0] !== 24'h112233) begin failures++; $display("FAIL split_a1_vi got=%h exp=112233", m_vi[23:0]); end
    step();
    checks++; if ({done, ready, m_we} !== 3'b110) begin failures++; $display("FAIL split_w_done got=%b exp=110", {done, ready, m_we}); end
    step();
    issue(1'b0, 2'd2, 17'h00007, 32'h0); run_to_done(cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL split_r_lat got=%0d exp=4", cyc); end
    checks++; if (rdata !== 32'h11223344) begin failures++; $display("FAIL split_r_data got=%h exp=11223344", rdata); end
    step();
  endtask

  task automatic test_wrap();
    int cyc;
    issue(1'b1, 2'd1, 17'h1FFFF, 32'h0000BEEF);
    checks++; if ({m_ai, m_bmsk, m_vi[31:24]} !== {15'h7FFF, 4'h8, 8'hEF}) begin failures++; $display("FAIL wrap_a0 got=%h/%h/%h exp=7fff/8/ef", m_ai, m_bmsk, m_vi[31:24]); end
    step();
    checks++; if ({m_ai, m_bmsk, m_vi[7:0]} !== {15'h0000, 4'h1, 8'hBE}) begin failures++; $display("FAIL wrap_a1 got=%h/%h/%h exp=0000/1/be", m_ai, m_bmsk, m_vi[7:0]); end
    run_to_done(cyc); step();
    issue(1'b0, 2'd1, 17'h1FFFF, 32'h0); run_to_done(cyc);
    checks++; if ({cyc[3:0], rdata} !== {4'd4, 32'h0000BEEF}) begin failures++; $display("FAIL wrap_rd got=%0d/%h exp=4/0000beef", cyc, rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'd2, 17'h00030, 32'h5A5A1234);
    step();
    checks++; if ({done, ready} !== 2'b11) begin failures++; $display("FAIL b2b_done_ready got=%b exp=11", {done, ready}); end
    issue(1'b0, 2'd2, 17'h00030, 32'h0);
    checks++; if ({ready, m_we, m_bmsk, m_ai} !== {1'b0, 1'b0, 4'hF, 15'h000C}) begin failures++; $display("FAIL b2b_a0 got=%b/%b/%h/%h exp=0/0/f/000c", ready, m_we, m_bmsk, m_ai); end
    issue(1'b1, 2'd2, 17'h00040, 32'hFFFFFFFF);
    checks++; if ({ready, m_we, m_bmsk, done} !== 7'b0_0_0000_0) begin failures++; $display("FAIL b2b_rl got=%b exp=0000000", {ready, m_we, m_bmsk, done}); end
    step();
    checks++; if ({done, rdata} !== {1'b1, 32'h5A5A1234}) begin failures++; $display("FAIL b2b_rd got=%b/%h exp=1/5a5a1234", done, rdata); end
    step();
    checks++; if ({ready, m_we, m_bmsk, done} !== 7'b1_0_0000_0) begin failures++; $display("FAIL b2b_dropped got=%b exp=1000000", {ready, m_we, m_bmsk, done}); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int dones;
    issue(1'b1, 2'd2, 17'h00044, 32'hCAFEF00D); run_to_done(cyc); step();
    issue(1'b1, 2'd2, 17'h00043, 32'h55667788);
    rst = 1'b1;
    step();
    checks++; if ({m_we, m_bmsk, done, ready} !== 7'b0_0000_0_1) begin failures++; $display("FAIL rmid_t2 got=%b exp=0000001", {m_we, m_bmsk, done, ready}); end
    step();
    checks++; if ({m_we, done, ready} !== 3'b001) begin failures++; $display("FAIL rmid_t3 got=%b exp=001", {m_we, done, ready}); end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || m_we) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rmid_no_activity got=%0d exp=0", dones); end
    issue(1'b0, 2'd2, 17'h00044, 32'h0); run_to_done(cyc);
    checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rmid_w1_kept got=%h exp=cafef00d", rdata); end
    step();
    issue(1'b0, 2'd0, 17'h00043, 32'h0); run_to_done(cyc);
    checks++; if (rdata !== 32'h00000088) begin failures++; $display("FAIL rmid_a0_written got=%h exp=00000088", rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_byte();
    test_split();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
